video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator pulling RGB565 pixels from a FIFO and emitting RGB888 with syncs
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        enable,
    input  logic        fifo_empty,
    output logic        fifo_read_req,
    input  logic [15:0] fifo_read_data,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state;
    logic            rst_hold;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            de1, hs1, vs1, rd1;

    logic running, h_wrap, v_wrap, active, hs_pos, vs_pos;

    assign running = (state != IDLE);
    assign h_wrap  = (h_cnt == H_LAST);
    assign v_wrap  = (v_cnt == V_LAST);
    assign active  = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_pos  = running && (h_cnt >= H_SS) && (h_cnt <= H_SE);
    assign vs_pos  = running && (v_cnt >= V_SS) && (v_cnt <= V_SE);

    assign fifo_read_req = active && !fifo_empty;
    assign frame_start   = running && (h_cnt == '0) && (v_cnt == '0);

    // Reset release is held off one edge so the first state change lands on the second clk after rest falls.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state     <= IDLE;
            h_cnt     <= '0;
            v_cnt     <= '0;
            de1       <= 1'b0;
            hs1       <= 1'b0;
            vs1       <= 1'b0;
            rd1       <= 1'b0;
            de        <= 1'b0;
            hsync     <= ~SYNC_POL;
            vsync     <= ~SYNC_POL;
            red       <= 8'd0;
            green     <= 8'd0;
            blue      <= 8'd0;
            underflow <= 1'b0;
        end else if (!rst_hold) begin
            if (running) begin
                if (h_wrap) begin
                    h_cnt <= '0;
                    v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end

            case (state)
                IDLE:    if (enable) state <= RUN;
                RUN:     if (!enable) state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if (h_wrap && v_wrap) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            de1 <= active;
            hs1 <= hs_pos;
            vs1 <= vs_pos;
            rd1 <= fifo_read_req;

            de    <= de1;
            hsync <= hs1 ^ ~SYNC_POL;
            vsync <= vs1 ^ ~SYNC_POL;
            // A starved active pixel still carries de but is forced black.
            if (rd1) begin
                red   <= {fifo_read_data[15:11], fifo_read_data[15:13]};
                green <= {fifo_read_data[10:5],  fifo_read_data[10:9]};
                blue  <= {fifo_read_data[4:0],   fifo_read_data[4:2]};
            end else begin
                red   <= 8'd0;
                green <= 8'd0;
                blue  <= 8'd0;
            end

            if (active && fifo_empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen with a small 7x5 raster
module tb_video_timing_gen;

    localparam int HA = 4, HT = 7, VA = 2, VT = 5;
    localparam int HS_POS = 5, VS_POS = 3;

    logic        clk = 1'b0;
    logic        rest, enable, fifo_empty;
    logic [15:0] fifo_read_data;
    logic        fifo_read_req, frame_start, hsync, vsync, de, underflow;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .rest(rest), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_req(fifo_read_req), .fifo_read_data(fifo_read_data),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .de(de),
        .red(red), .green(green), .blue(blue), .underflow(underflow)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    int          m_state, m_h, m_v, pix_n = 0;
    bit          m_hold, m_uf, arm_empty = 0, pend_valid = 0;
    logic [15:0] pend_word;
    logic [15:0] pix_list [3] = '{16'hF800, 16'h07E0, 16'h001F};

    function automatic logic [23:0] expand(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_t z;
        z = '0;
        m_state = 0; m_h = 0; m_v = 0; m_uf = 0; m_hold = 1; pend_valid = 0;
        q.delete();
        q.push_back(z);
        q.push_back(z);
    endtask

    task automatic check_reset_values();
        chk("rst_de", de, 1'b0);
        chk("rst_hsync", hsync, 1'b0);
        chk("rst_vsync", vsync, 1'b0);
        chk("rst_rgb", {red, green, blue}, 24'h0);
        chk("rst_req", fifo_read_req, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
    endtask

    task automatic advance();
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
    endtask

    // Entered at posedge+1; drives cycle P, checks it, predicts P+2, steps the model.
    task automatic cyc(input bit en);
        exp_t e, n;
        bit act, emp, req, last;
        enable = en;
        act = (m_state != 0) && (m_h < HA) && (m_v < VA);
        emp = arm_empty && act && (m_h == 2) && (m_v == 0);
        if (emp) arm_empty = 0;
        fifo_empty = emp;
        fifo_read_data = pend_valid ? pend_word : 16'($urandom);
        #1;
        req = act && !emp;
        chk("fifo_read_req", fifo_read_req, req);
        chk("frame_start", frame_start, (m_state != 0) && (m_h == 0) && (m_v == 0));
        e = q.pop_front();
        chk("de", de, e.de);
        chk("hsync", hsync, e.hs);
        chk("vsync", vsync, e.vs);
        chk("rgb", {red, green, blue}, e.rgb);
        chk("underflow", underflow, m_uf);
        if (req) begin
            pend_word = (pix_n < 3) ? pix_list[pix_n] : 16'($urandom);
            pix_n++;
            pend_valid = 1;
        end else begin
            pend_valid = 0;
        end
        n.de  = act;
        n.hs  = (m_state != 0) && (m_h == HS_POS);
        n.vs  = (m_state != 0) && (m_v == VS_POS);
        n.rgb = req ? expand(pend_word) : 24'h0;
        q.push_back(n);
        if (m_hold) begin
            m_hold = 0;
        end else begin
            if (act && emp) m_uf = 1;
            last = (m_h == HT - 1) && (m_v == VT - 1);
            case (m_state)
                0: if (en) m_state = 1;
                1: begin advance(); if (!en) m_state = 2; end
                default: begin
                    advance();
                    if (en) m_state = 1;
                    else if (last) m_state = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rest = 1'b1; enable = 1'b0; fifo_empty = 1'b0; fifo_read_data = 16'h0;
        #3;
        check_reset_values();
        @(posedge clk); @(posedge clk); #1;
        rest = 1'b0;
        reset_model();

        for (int i = 0; i < 80; i++) cyc(1'b1);

        arm_empty = 1;
        for (int i = 0; i < 40; i++) cyc(1'b1);
        chk("empty_pixel_reached", arm_empty, 1'b0);

        for (int i = 0; i < 40 && m_v != 1; i++) cyc(1'b1);
        chk("reach_line1", m_v, 1);
        for (int i = 0; i < 50; i++) cyc(1'b0);
        chk("drained_to_idle", m_state, 0);
        for (int i = 0; i < 20; i++) cyc(1'b1);

        for (int i = 0; i < 3; i++) cyc(1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1);

        for (int i = 0; i < 40 && !(m_h == 2 && m_v == 1); i++) cyc(1'b1);
        chk("reach_mid_frame", (m_h == 2) && (m_v == 1), 1'b1);
        rest = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk); #1;
        rest = 1'b0;
        reset_model();
        for (int i = 0; i < 45; i++) cyc(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
